// File: rtl/inst_axi_rd_bridge.sv
// -----------------------------------------------------------------------------
// inst_axi_rd_bridge
//   Instruction-side fetch bridge. Converts the SRAM-like fetch handshake
//   (req / addr_ok / data_ok) used by if_stage into a single-beat AXI read
//   master (AR and R channels only).
//
//   - Up to MAX_OUT fetches may be accepted but not yet returned.
//   - An exception flush (ws_handle_ex) marks every fetch still in flight as
//     stale; their R beats are consumed silently so if_stage never sees them.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   inst_sram_req/wr/size/addr     fetch request from if_stage (wr must be 0)
//   inst_sram_wstrb/wdata          unused (read-only port)
//   inst_sram_addrok               request accepted this cycle
//   inst_sram_dataok/rdata         fetched instruction valid this cycle
//   ws_handle_ex                   flush: discard all in-flight fetches
//   ar*                            AXI read-address channel (master side)
//   rid/rdata/rresp/rlast/rvalid   AXI read-data channel (rid/rresp/rlast ignored)
//   rready                         always 1; if_stage buffers the data itself
// -----------------------------------------------------------------------------

// Protocol checker: an R beat may only arrive while a fetch is outstanding.
module inst_axi_rd_bridge_chk (
    input  logic       clk,
    input  logic       reset,
    input  logic       r_fire,
    input  logic [1:0] out_cnt
);

    // No R beat is legal when nothing has been requested.
    a_no_orphan_r : assert property (@(posedge clk) disable iff (reset)
        r_fire |-> (out_cnt != 2'd0));

endmodule

module inst_axi_rd_bridge #(
    parameter logic [3:0] AR_ID   = 4'd0,
    parameter int         MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addrok,
    output logic        inst_sram_dataok,
    output logic [31:0] inst_sram_rdata,

    input  logic        ws_handle_ex,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam logic [1:0] MAX_OUT_C = 2'(MAX_OUT);

    typedef enum logic [0:0] {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_t;

    ar_state_t   state_r;
    ar_state_t   state_nxt_s;
    logic [1:0]  out_cnt_r;
    logic [1:0]  out_cnt_nxt_s;
    logic [1:0]  drop_cnt_r;
    logic [1:0]  drop_cnt_nxt_s;
    logic [31:0] araddr_r;
    logic [2:0]  arsize_r;
    logic        addr_ok_s;
    logic        r_fire_s;
    logic        unused_s;

    // Read-only port: write payload, RID, RRESP and RLAST carry no information here.
    assign unused_s = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

    // Acceptance is combinational so a request can be taken in the cycle it appears;
    // reset gates it so nothing is accepted while state is being cleared.
    assign addr_ok_s = (state_r == AR_IDLE) & inst_sram_req & ~inst_sram_wr
                     & (out_cnt_r < MAX_OUT_C) & ~reset;
    assign r_fire_s  = rvalid & rready;

    // Fetch-side outputs.
    assign inst_sram_addrok = addr_ok_s;
    assign inst_sram_dataok = rvalid & (drop_cnt_r == 2'd0) & ~ws_handle_ex;
    assign inst_sram_rdata  = rdata;

    // AXI AR channel: single-beat incrementing reads with a fixed ID.
    assign arid    = AR_ID;
    assign araddr  = araddr_r;
    assign arlen   = 8'd0;
    assign arsize  = arsize_r;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state_r == AR_SEND);
    assign rready  = 1'b1;

    // AR FSM next state: arvalid is held until the handshake, flush or not.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            AR_IDLE: begin
                if (addr_ok_s) begin
                    state_nxt_s = AR_SEND;
                end else begin
                    state_nxt_s = AR_IDLE;
                end
            end
            AR_SEND: begin
                if (arready) begin
                    state_nxt_s = AR_IDLE;
                end else begin
                    state_nxt_s = AR_SEND;
                end
            end
            default: state_nxt_s = AR_IDLE;
        endcase
    end

    // Outstanding-fetch count: simultaneous accept and return cancel out.
    always_comb begin
        out_cnt_nxt_s = out_cnt_r;
        case ({addr_ok_s, r_fire_s})
            2'b10: out_cnt_nxt_s = out_cnt_r + 2'd1;
            2'b01: begin
                // An orphan beat is flagged by the checker; saturate rather than wrap.
                if (out_cnt_r != 2'd0) begin
                    out_cnt_nxt_s = out_cnt_r - 2'd1;
                end else begin
                    out_cnt_nxt_s = 2'd0;
                end
            end
            default: out_cnt_nxt_s = out_cnt_r;
        endcase
    end

    // Drop count: a flush snapshots everything still unreturned after this cycle
    // (a fresh flush replaces, never adds to, the previous count).
    always_comb begin
        drop_cnt_nxt_s = drop_cnt_r;
        if (ws_handle_ex) begin
            drop_cnt_nxt_s = out_cnt_nxt_s;
        end else if (r_fire_s && (drop_cnt_r != 2'd0)) begin
            drop_cnt_nxt_s = drop_cnt_r - 2'd1;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // State, counter and AR payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= AR_IDLE;
            out_cnt_r  <= 2'd0;
            drop_cnt_r <= 2'd0;
            araddr_r   <= 32'd0;
            arsize_r   <= 3'd0;
        end else begin
            state_r    <= state_nxt_s;
            out_cnt_r  <= out_cnt_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
            if (addr_ok_s) begin
                araddr_r <= inst_sram_addr;
                arsize_r <= {1'b0, inst_sram_size};
            end
        end
    end

    inst_axi_rd_bridge_chk u_chk (
        .clk     (clk),
        .reset   (reset),
        .r_fire  (r_fire_s),
        .out_cnt (out_cnt_r)
    );

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// -----------------------------------------------------------------------------
// tb_inst_axi_rd_bridge
//   Directed testbench for inst_axi_rd_bridge. Each bench cycle: inputs are
//   driven 1 ns after the rising edge, outputs are compared 1 ns later, and
//   registered state advances on the next rising edge.
// -----------------------------------------------------------------------------
module tb_inst_axi_rd_bridge;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addrok;
    logic        dataok;
    logic [31:0] inst_rdata;
    logic        ws_ex;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_vec;
    int n_err;

    inst_axi_rd_bridge #(.AR_ID(4'd0), .MAX_OUT(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .inst_sram_req    (req),
        .inst_sram_wr     (wr),
        .inst_sram_size   (size),
        .inst_sram_addr   (addr),
        .inst_sram_wstrb  (wstrb),
        .inst_sram_wdata  (wdata),
        .inst_sram_addrok (addrok),
        .inst_sram_dataok (dataok),
        .inst_sram_rdata  (inst_rdata),
        .ws_handle_ex     (ws_ex),
        .arid             (arid),
        .araddr           (araddr),
        .arlen            (arlen),
        .arsize           (arsize),
        .arburst          (arburst),
        .arlock           (arlock),
        .arcache          (arcache),
        .arprot           (arprot),
        .arvalid          (arvalid),
        .arready          (arready),
        .rid              (rid),
        .rdata            (rdata),
        .rresp            (rresp),
        .rlast            (rlast),
        .rvalid           (rvalid),
        .rready           (rready)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and return every input to its idle value.
    task automatic nxt();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        req     = 1'b0;
        wr      = 1'b0;
        size    = 2'd2;
        addr    = 32'd0;
        wstrb   = 4'd0;
        wdata   = 32'd0;
        ws_ex   = 1'b0;
        arready = 1'b0;
        rid     = 4'd0;
        rdata   = 32'd0;
        rresp   = 2'd0;
        rlast   = 1'b1;
        rvalid  = 1'b0;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    int acc_cnt;
    int max_out;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2; addr = 32'd0;
        wstrb = 4'd0; wdata = 32'd0; ws_ex = 1'b0; arready = 1'b0;
        rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;

        // ---------------- reset ----------------
        nxt(); reset = 1'b1; req = 1'b1; addr = 32'h1000_0000;
        settle();
        check_vec("rst_addrok", {31'd0, addrok}, 32'd0);
        nxt(); reset = 1'b1;
        settle();
        check_vec("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check_vec("rst_rready", {31'd0, rready}, 32'd1);
        check_vec("rst_dataok", {31'd0, dataok}, 32'd0);
        check_vec("rst_araddr", araddr, 32'd0);
        check_vec("rst_arsize", {29'd0, arsize}, 32'd0);
        check_vec("rst_outcnt", {30'd0, dut.out_cnt_r}, 32'd0);
        check_vec("rst_dropcnt", {30'd0, dut.drop_cnt_r}, 32'd0);

        // Write requests are never accepted.
        nxt(); req = 1'b1; wr = 1'b1; addr = 32'h2000_0000;
        settle();
        check_vec("wr_ignored", {31'd0, addrok}, 32'd0);

        // ---------------- 1: single fetch, minimum latency ----------------
        nxt(); req = 1'b1; addr = 32'hbfc0_0000;
        settle();
        check_vec("t1_addrok", {31'd0, addrok}, 32'd1);
        check_vec("t1_arvalid_c0", {31'd0, arvalid}, 32'd0);
        nxt(); arready = 1'b1;
        settle();
        check_vec("t1_arvalid_c1", {31'd0, arvalid}, 32'd1);
        check_vec("t1_araddr", araddr, 32'hbfc0_0000);
        check_vec("t1_arsize", {29'd0, arsize}, 32'd2);
        check_vec("t1_arlen", {24'd0, arlen}, 32'd0);
        check_vec("t1_arburst", {30'd0, arburst}, 32'd1);
        check_vec("t1_arid", {28'd0, arid}, 32'd0);
        check_vec("t1_arcache_prot_lock", {23'd0, arcache, arprot, arlock}, 32'd0);
        nxt(); rvalid = 1'b1; rdata = 32'h3c1d_0000;
        settle();
        check_vec("t1_dataok", {31'd0, dataok}, 32'd1);
        check_vec("t1_rdata", inst_rdata, 32'h3c1d_0000);
        check_vec("t1_arvalid_c2", {31'd0, arvalid}, 32'd0);
        nxt();
        settle();
        check_vec("t1_dataok_off", {31'd0, dataok}, 32'd0);
        check_vec("t1_outcnt_end", {30'd0, dut.out_cnt_r}, 32'd0);

        // ---------------- 2: MAX_OUT limit with req held high ----------------
        acc_cnt = 0;
        max_out = 0;
        for (int i = 0; i < 10; i++) begin
            nxt(); req = 1'b1; addr = 32'hbfc0_0010; arready = 1'b1;
            settle();
            if (addrok) acc_cnt++;
            if (int'(dut.out_cnt_r) > max_out) max_out = int'(dut.out_cnt_r);
        end
        check_vec("t2_accepts", acc_cnt, 32'd2);
        check_vec("t2_max_out", max_out, 32'd2);
        nxt(); req = 1'b1; arready = 1'b1; rvalid = 1'b1; rdata = 32'h1111_1111;
        settle();
        check_vec("t2_addrok_full", {31'd0, addrok}, 32'd0);
        check_vec("t2_dataok1", {31'd0, dataok}, 32'd1);
        check_vec("t2_rdata1", inst_rdata, 32'h1111_1111);
        nxt(); req = 1'b1; addr = 32'hbfc0_0020; arready = 1'b1;
        settle();
        check_vec("t2_addrok_again", {31'd0, addrok}, 32'd1);
        nxt(); arready = 1'b1;
        settle();
        check_vec("t2_araddr3", araddr, 32'hbfc0_0020);
        nxt(); rvalid = 1'b1; rdata = 32'h2222_2222;
        settle();
        check_vec("t2_dataok2", {31'd0, dataok}, 32'd1);
        nxt(); rvalid = 1'b1; rdata = 32'h3333_3333;
        settle();
        check_vec("t2_dataok3", {31'd0, dataok}, 32'd1);
        nxt();
        settle();
        check_vec("t2_outcnt_end", {30'd0, dut.out_cnt_r}, 32'd0);

        // ---------------- 3: flush while AR stalled ----------------
        nxt(); req = 1'b1; addr = 32'hbfc0_0100;
        settle();
        check_vec("t3_addrok", {31'd0, addrok}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            nxt(); ws_ex = (k == 2); req = 1'b1; addr = 32'h0bad_0000;
            settle();
            check_vec("t3_arvalid_hold", {31'd0, arvalid}, 32'd1);
            check_vec("t3_araddr_hold", araddr, 32'hbfc0_0100);
            check_vec("t3_no_addrok", {31'd0, addrok}, 32'd0);
        end
        check_vec("t3_dropcnt", {30'd0, dut.drop_cnt_r}, 32'd1);
        nxt(); arready = 1'b1;
        settle();
        check_vec("t3_arvalid_hs", {31'd0, arvalid}, 32'd1);
        check_vec("t3_araddr_hs", araddr, 32'hbfc0_0100);
        nxt(); rvalid = 1'b1; rdata = 32'hdead_beef;
        settle();
        check_vec("t3_dropped", {31'd0, dataok}, 32'd0);
        nxt();
        settle();
        check_vec("t3_dropcnt_end", {30'd0, dut.drop_cnt_r}, 32'd0);
        check_vec("t3_outcnt_end", {30'd0, dut.out_cnt_r}, 32'd0);

        // ---------------- 4: two in flight, flush, new fetch ----------------
        nxt(); req = 1'b1; addr = 32'hbfc0_0200;
        settle();
        check_vec("t4_addrok_a", {31'd0, addrok}, 32'd1);
        nxt(); arready = 1'b1;
        settle();
        nxt(); req = 1'b1; addr = 32'hbfc0_0204;
        settle();
        check_vec("t4_addrok_b", {31'd0, addrok}, 32'd1);
        nxt(); arready = 1'b1;
        settle();
        nxt(); ws_ex = 1'b1;
        settle();
        check_vec("t4_dataok_flush", {31'd0, dataok}, 32'd0);
        nxt(); req = 1'b1; addr = 32'hbfc0_0380; rvalid = 1'b1; rdata = 32'haaaa_aaaa;
        settle();
        check_vec("t4_drop1", {31'd0, dataok}, 32'd0);
        check_vec("t4_addrok_full", {31'd0, addrok}, 32'd0);
        nxt(); req = 1'b1; addr = 32'hbfc0_0380; rvalid = 1'b1; rdata = 32'hbbbb_bbbb;
        settle();
        check_vec("t4_drop2", {31'd0, dataok}, 32'd0);
        check_vec("t4_addrok_new", {31'd0, addrok}, 32'd1);
        nxt(); arready = 1'b1;
        settle();
        check_vec("t4_araddr_new", araddr, 32'hbfc0_0380);
        nxt(); rvalid = 1'b1; rdata = 32'h0800_0380;
        settle();
        check_vec("t4_dataok_new", {31'd0, dataok}, 32'd1);
        check_vec("t4_rdata_new", inst_rdata, 32'h0800_0380);
        nxt();
        settle();
        check_vec("t4_outcnt_end", {30'd0, dut.out_cnt_r}, 32'd0);

        // ---------------- 5: flush + accept + R beat in one cycle ----------------
        nxt(); req = 1'b1; addr = 32'hbfc0_0400;
        settle();
        nxt(); arready = 1'b1;
        settle();
        nxt(); req = 1'b1; addr = 32'hbfc0_0404; rvalid = 1'b1; rdata = 32'hcccc_cccc; ws_ex = 1'b1;
        settle();
        check_vec("t5_addrok", {31'd0, addrok}, 32'd1);
        check_vec("t5_dataok", {31'd0, dataok}, 32'd0);
        nxt(); arready = 1'b1;
        settle();
        check_vec("t5_dropcnt", {30'd0, dut.drop_cnt_r}, 32'd1);
        check_vec("t5_outcnt", {30'd0, dut.out_cnt_r}, 32'd1);
        nxt(); rvalid = 1'b1; rdata = 32'hdddd_dddd;
        settle();
        check_vec("t5_next_dropped", {31'd0, dataok}, 32'd0);
        nxt();
        settle();
        check_vec("t5_dropcnt_end", {30'd0, dut.drop_cnt_r}, 32'd0);
        check_vec("t5_outcnt_end", {30'd0, dut.out_cnt_r}, 32'd0);

        // ---------------- 6: reset in AR_SEND ----------------
        nxt(); req = 1'b1; addr = 32'hbfc0_0500;
        settle();
        check_vec("t6_addrok", {31'd0, addrok}, 32'd1);
        nxt(); ws_ex = 1'b1;
        settle();
        check_vec("t6_arvalid_send", {31'd0, arvalid}, 32'd1);
        nxt(); reset = 1'b1; req = 1'b1;
        settle();
        check_vec("t6_addrok_in_rst", {31'd0, addrok}, 32'd0);
        check_vec("t6_dropcnt_pre", {30'd0, dut.drop_cnt_r}, 32'd1);
        nxt(); req = 1'b1; addr = 32'hbfc0_0600;
        settle();
        check_vec("t6_arvalid_clr", {31'd0, arvalid}, 32'd0);
        check_vec("t6_outcnt_clr", {30'd0, dut.out_cnt_r}, 32'd0);
        check_vec("t6_dropcnt_clr", {30'd0, dut.drop_cnt_r}, 32'd0);
        check_vec("t6_addrok_avail", {31'd0, addrok}, 32'd1);
        nxt(); arready = 1'b1;
        settle();
        check_vec("t6_araddr", araddr, 32'hbfc0_0600);
        nxt(); rvalid = 1'b1; rdata = 32'h1234_5678;
        settle();
        check_vec("t6_dataok", {31'd0, dataok}, 32'd1);
        check_vec("t6_rdata", inst_rdata, 32'h1234_5678);
        nxt();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
